// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: breaks one vector load/store into LANES
// consecutive word or halfword beats on a single-beat memory port,
// assembles the load result and signals completion to the pipeline.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// ACCESS | issuing one beat per lane, advancing on mem_ready
// FINISH | one-cycle done pulse, vec_we for loads, pipeline released
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic                    half,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] store_vec,
  input  logic                    mem_ready,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_half,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [LANES*DATA_W-1:0] load_vec,
  output logic                    vec_we,
  output logic                    stall,
  output logic                    busy,
  output logic                    done
);

  localparam int LANE_W = $clog2(LANES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [1:0]              state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic                    half_q, half_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES*DATA_W-1:0] store_q, store_d;
  logic [LANES*DATA_W-1:0] load_vec_q, load_vec_d;
  logic [LANE_W-1:0]       lane_q, lane_d;

  logic                    in_idle, in_access, in_finish;
  logic [ADDR_W-1:0]       lane_a, lane_off;
  logic [DATA_W-1:0]       lane_word;
  int unsigned             lane_idx;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);
  assign in_finish = (state_q == ST_FINISH);

  // Lane byte offset is lane*2 or lane*4; the add below wraps modulo 2^ADDR_W.
  assign lane_idx  = 32'(lane_q);
  assign lane_a    = ADDR_W'(lane_q);
  assign lane_off  = half_q ? (lane_a << 1) : (lane_a << 2);
  assign lane_word = store_q[lane_idx*DATA_W +: DATA_W];

  // Next-state, operand latch, lane counter and load assembly
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    half_d     = half_q;
    base_d     = base_q;
    store_d    = store_q;
    lane_d     = lane_q;
    load_vec_d = load_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          half_d     = half;
          base_d     = base_addr;
          store_d    = store_vec;
          lane_d     = '0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          if (!is_store_q) begin
            load_vec_d[lane_idx*DATA_W +: DATA_W] =
              half_q ? DATA_W'(mem_rdata[15:0]) : mem_rdata;
          end
          if (lane_q == LAST_LANE) begin
            state_d = ST_FINISH;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        // start here is deliberately dropped; it is taken on the next IDLE cycle
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      half_q     <= 1'b0;
      base_q     <= '0;
      store_q    <= '0;
      lane_q     <= '0;
      load_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      half_q     <= half_d;
      base_q     <= base_d;
      store_q    <= store_d;
      lane_q     <= lane_d;
      load_vec_q <= load_vec_d;
    end
  end

  // Memory port is decoded purely from state and latched operands, so it
  // holds steady while mem_ready is low and is zero outside ACCESS.
  always_comb begin
    mem_req   = in_access;
    mem_we    = in_access & is_store_q;
    mem_half  = in_access & half_q;
    mem_addr  = in_access ? (base_q + lane_off) : '0;
    mem_wdata = '0;
    if (in_access) begin
      mem_wdata = half_q ? DATA_W'(lane_word[15:0]) : lane_word;
    end
  end

  // Pipeline handshake: stall drops in FINISH so the stage advances with done
  always_comb begin
    vec_we   = in_finish & ~is_store_q;
    done     = in_finish;
    busy     = ~in_idle;
    stall    = in_access | (in_idle & start);
    load_vec = load_vec_q;
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: a table of whole vector ops checked beat by
// beat against a scoreboard queue, plus hand sequences for reset abort and
// back-to-back starts.
module tb_vec_mem_sequencer;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int VW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic              half = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [VW-1:0]     store_vec = '0;
  logic              mem_ready = 1'b1;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req, mem_we, mem_half;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [VW-1:0]     load_vec;
  logic              vec_we, stall, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: read data is seed + lane index, recovered from the address
  logic [31:0] cur_base = '0;
  logic [31:0] cur_seed = '0;
  logic        cur_half = 1'b0;

  always_comb mem_rdata = cur_seed + ((mem_addr - cur_base) >> (cur_half ? 32'd1 : 32'd2));

  always #5 clk = ~clk;

  vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .half(half),
    .base_addr(base_addr), .store_vec(store_vec), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_half(mem_half), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_vec(load_vec), .vec_we(vec_we), .stall(stall), .busy(busy),
    .done(done)
  );

  typedef struct {
    logic          is_store;
    logic          half;
    logic [31:0]   base;
    logic [VW-1:0] svec;
    logic [31:0]   seed;
    int            ready_lane;
    int            ready_hold;
    logic [VW-1:0] exp_load;
    int            exp_done;
  } vec_t;

  typedef struct {
    logic        we;
    logic        hf;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  vec_t  tbl[6];
  beat_t sb[$];

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req"}, mem_req, 0);
    chk({nm, "_we"}, mem_we, 0);
    chk({nm, "_half"}, mem_half, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_load"}, load_vec, 0);
    chk({nm, "_vecwe"}, vec_we, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  // Issue one op from IDLE and follow it to done, scoring every beat
  task automatic run_op(input vec_t v);
    int    k;
    int    waits;
    logic  got_done;
    beat_t e;
    @(negedge clk);
    chk("pre_busy", busy, 0);
    start = 1'b1; is_store = v.is_store; half = v.half;
    base_addr = v.base; store_vec = v.svec;
    cur_base = v.base; cur_half = v.half; cur_seed = v.seed;
    mem_ready = 1'b1;
    #1 chk("start_stall", stall, 1);
    for (int i = 0; i < LANES; i++) begin
      e.we    = v.is_store;
      e.hf    = v.half;
      e.addr  = v.base + 32'(i) * (v.half ? 32'd2 : 32'd4);
      e.wdata = v.half ? {16'h0, v.svec[i*DATA_W +: 16]} : v.svec[i*DATA_W +: DATA_W];
      sb.push_back(e);
    end
    k = 0; waits = 0; got_done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", cyc, v.exp_done);
        chk("done_vecwe", vec_we, !v.is_store);
        chk("done_stall", stall, 0);
        chk("done_req", mem_req, 0);
      end else begin
        chk("acc_req", mem_req, 1);
        chk("acc_stall", stall, 1);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("beat_addr", mem_addr, e.addr);
          chk("beat_wdata", mem_wdata, e.wdata);
          chk("beat_we", mem_we, e.we);
          chk("beat_half", mem_half, e.hf);
        end
        if (k == v.ready_lane && waits < v.ready_hold) begin
          mem_ready = 1'b0;
          waits++;
        end else begin
          mem_ready = 1'b1;
          if (sb.size() > 0) void'(sb.pop_front());
          k++;
        end
      end
    end
    chk("op_completed", got_done, 1);
    mem_ready = 1'b1;
    chk("load_vec", load_vec, v.exp_load);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v;
    logic  seen_done;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, '0, 32'h0000_00A0, -1, 0,
               128'h000000A3_000000A2_000000A1_000000A0, 5};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0200,
               128'h9ABCDEF0_11223344_CAFEBABE_12345678, 32'h0, -1, 0,
               128'h000000A3_000000A2_000000A1_000000A0, 5};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0300,
               128'h0BADF00D_DEADBEEF_55AA55AA_01020304, 32'h0, 2, 3,
               128'h000000A3_000000A2_000000A1_000000A0, 8};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, '0, 32'h0000_1000, -1, 0,
               128'h00001003_00001002_00001001_00001000, 5};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0041, '0, 32'hDEAD_FFF0, -1, 0,
               128'h0000FFF3_0000FFF2_0000FFF1_0000FFF0, 5};
    tbl[5] = '{1'b0, 1'b0, 32'h0000_0500, '0, 32'h0000_0077, 0, 2,
               128'h0000007A_00000079_00000078_00000077, 7};

    // Reset state, then release so the first start meets the first live edge
    #1 check_all_zero("rst");
    repeat (3) @(posedge clk);
    check_all_zero("rst_held");
    #1 rst = 1'b1;

    for (int t = 0; t < 6; t++) run_op(tbl[t]);

    // Reset during lane 1 of a load abandons it
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; half = 1'b0; base_addr = 32'h0000_0900;
    cur_base = 32'h0000_0900; cur_half = 1'b0; cur_seed = 32'h0000_0042;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_lane0", mem_addr, 32'h0000_0900);
    @(negedge clk);
    chk("abort_lane1", mem_addr, 32'h0000_0904);
    rst = 1'b0;
    #1 check_all_zero("abort");
    chk("abort_stall", stall, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_vecwe", vec_we, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    v = '{1'b0, 1'b0, 32'h0000_0A00, '0, 32'h0000_0055, -1, 0,
          128'h00000058_00000057_00000056_00000055, 5};
    run_op(v);

    // start held high: busy and FINISH starts are ignored, IDLE start taken
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; half = 1'b0; base_addr = 32'h0000_0600;
    cur_base = 32'h0000_0600; cur_half = 1'b0; cur_seed = 32'h0000_0010;
    mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) begin
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, 32'h0000_0600 + 32'(cyc - 1) * 32'd4);
        chk("hold_we", mem_we, 0);
        base_addr = 32'h0000_0700; is_store = 1'b1;
      end else if (cyc == 5) begin
        chk("hold_done", done, 1);
        chk("hold_vecwe", vec_we, 1);
        chk("hold_fin_stall", stall, 0);
        chk("hold_load", load_vec, 128'h00000013_00000012_00000011_00000010);
        base_addr = 32'h0000_0900;
      end else if (cyc == 6) begin
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_stall", stall, 1);
        chk("hold_idle_done", done, 0);
        base_addr = 32'h0000_0800; is_store = 1'b0;
        cur_base = 32'h0000_0800; cur_seed = 32'h0000_0020;
      end else begin
        chk("hold2_req", mem_req, 1);
        chk("hold2_addr", mem_addr, 32'h0000_0800);
        start = 1'b0;
      end
    end
    seen_done = 1'b0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("hold2_done", seen_done, 1);
    chk("hold2_load", load_vec, 128'h00000023_00000022_00000021_00000020);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
